// File: rtl/fetch_pkg.sv
// Shared instruction-format constants for the fetch stage and its neighbours.
package fetch_pkg;

  localparam int BUNDLE_W = 64;

  typedef enum logic [5:0] {
    Nop = 6'h3F,
    Add = 6'h01,
    Ld  = 6'h02,
    St  = 6'h03,
    Br  = 6'h04,
    Bl  = 6'h05
  } opcode_t;

  // Two Nop slots, each with a zeroed 26-bit operand field.
  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = {Nop, 26'd0, Nop, 26'd0};

endpackage

// File: rtl/fetch_hold.sv
// Stall capture register plus the presented-bundle mux feeding decode.
module fetch_hold
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                interlock,
  input  logic                branch_flag,
  input  logic                inflight_valid,
  input  logic [31:0]         inflight_pc,
  input  logic [BUNDLE_W-1:0] imem_dout,
  output logic [31:0]         pc,
  output logic [BUNDLE_W-1:0] inst,
  output logic                fetch_valid
);

  logic [31:0]         hold_pc;
  logic [BUNDLE_W-1:0] hold_inst;
  logic                hold_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_pc    <= 32'd0;
      hold_inst  <= NOP_BUNDLE;
      hold_valid <= 1'b0;
    end else if (branch_flag) begin
      hold_valid <= 1'b0;
    end else if (interlock) begin
      // Capture only once per stall; the BRAM data vanishes after this cycle.
      if (!hold_valid && inflight_valid) begin
        hold_pc    <= inflight_pc;
        hold_inst  <= imem_dout;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    pc   = 32'd0;
    inst = NOP_BUNDLE;
    if (hold_valid) begin
      pc   = hold_pc;
      inst = hold_inst;
    end else if (inflight_valid) begin
      pc   = inflight_pc;
      inst = imem_dout;
    end
  end

  assign fetch_valid = hold_valid | inflight_valid;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: bundle address sequencing, redirect handling and BRAM read tracking.
module fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                interlock,
  input  logic                branch_flag,
  input  logic [31:0]         branch_pc,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [BUNDLE_W-1:0] imem_dout,
  output logic [31:0]         pc,
  output logic [BUNDLE_W-1:0] inst,
  output logic                fetch_valid
);

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight_valid;

  // Redirect target is issued in the same cycle it arrives, so no extra bubble.
  assign imem_addr = branch_flag ? branch_pc[ADDR_W-1:0] : fetch_pc[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc       <= RESET_PC;
      inflight_pc    <= 32'd0;
      inflight_valid <= 1'b0;
    end else if (branch_flag) begin
      inflight_pc    <= branch_pc;
      inflight_valid <= 1'b1;
      fetch_pc       <= branch_pc + 32'd1;
    end else if (interlock) begin
      inflight_valid <= 1'b0;
    end else begin
      inflight_pc    <= fetch_pc;
      inflight_valid <= 1'b1;
      fetch_pc       <= fetch_pc + 32'd1;
    end
  end

  fetch_hold u_hold (
    .clk            (clk),
    .rstn           (rstn),
    .interlock      (interlock),
    .branch_flag    (branch_flag),
    .inflight_valid (inflight_valid),
    .inflight_pc    (inflight_pc),
    .imem_dout      (imem_dout),
    .pc             (pc),
    .inst           (inst),
    .fetch_valid    (fetch_valid)
  );

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a presented-bundle model checked every cycle plus directed literals.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        interlock;
  logic        branch_flag;
  logic [31:0] branch_pc;

  logic [14:0] b_addr;
  logic [63:0] b_dout;
  logic [31:0] b_pc;
  logic [63:0] b_inst;
  logic        b_valid;

  logic [3:0]  s_addr;
  logic [63:0] s_dout;
  logic [31:0] s_pc;
  logic [63:0] s_inst;
  logic        s_valid;

  int total = 0;
  int bad   = 0;

  // Model state: what decode must see, independent of how the RTL stores it.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  always #5 clk = ~clk;

  fetch #(.ADDR_W(15), .RESET_PC(32'h0)) dut_big (
    .clk(clk), .rstn(rstn), .interlock(interlock), .branch_flag(branch_flag),
    .branch_pc(branch_pc), .imem_addr(b_addr), .imem_dout(b_dout),
    .pc(b_pc), .inst(b_inst), .fetch_valid(b_valid)
  );

  fetch #(.ADDR_W(4), .RESET_PC(32'h0)) dut_small (
    .clk(clk), .rstn(rstn), .interlock(interlock), .branch_flag(branch_flag),
    .branch_pc(branch_pc), .imem_addr(s_addr), .imem_dout(s_dout),
    .pc(s_pc), .inst(s_inst), .fetch_valid(s_valid)
  );

  function automatic logic [63:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0], 16'h5EED, a[15:0]};
  endfunction

  always @(posedge clk) begin
    b_dout <= word({17'd0, b_addr});
    s_dout <= word({28'd0, s_addr});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_pc    <= 32'd0;
      m_next  <= 32'h0;
    end else if (branch_flag) begin
      m_valid <= 1'b1;
      m_pc    <= branch_pc;
      m_next  <= branch_pc + 32'd1;
    end else if (!interlock) begin
      m_valid <= 1'b1;
      m_pc    <= m_next;
      m_next  <= m_next + 32'd1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea;
    ea = branch_flag ? branch_pc : m_next;
    chk("big_valid", {63'd0, b_valid}, {63'd0, m_valid});
    chk("big_pc", {32'd0, b_pc}, {32'd0, m_valid ? m_pc : 32'd0});
    chk("big_inst", b_inst, m_valid ? word({17'd0, m_pc[14:0]}) : NOP_BUNDLE);
    chk("big_addr", {49'd0, b_addr}, {49'd0, ea[14:0]});
    chk("small_valid", {63'd0, s_valid}, {63'd0, m_valid});
    chk("small_pc", {32'd0, s_pc}, {32'd0, m_valid ? m_pc : 32'd0});
    chk("small_inst", s_inst, m_valid ? word({28'd0, m_pc[3:0]}) : NOP_BUNDLE);
    chk("small_addr", {60'd0, s_addr}, {60'd0, ea[3:0]});
  end

  task automatic step(input logic b, input logic [31:0] t, input logic il);
    branch_flag = b;
    branch_pc   = t;
    interlock   = il;
    @(posedge clk);
    #1;
    $display("cycle t=%0t br=%0b bpc=%h il=%0b -> pc=%h valid=%0b addr=%h",
             $time, b, t, il, b_pc, b_valid, b_addr);
  endtask

  initial begin
    rstn = 1'b0; interlock = 1'b0; branch_flag = 1'b0; branch_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", {32'd0, b_pc}, 64'd0);
    chk("reset_inst", b_inst, 64'hFC000000_FC000000);
    chk("reset_valid", {63'd0, b_valid}, 64'd0);
    rstn = 1'b1;

    // Streaming from RESET_PC: pc = 0,1,2,...
    step(0, 0, 0);
    chk("first_pc", {32'd0, b_pc}, 64'd0);
    chk("first_inst", b_inst, 64'hC0DE0000_5EED0000);
    for (int k = 1; k <= 5; k++) step(0, 0, 0);
    chk("pc5", {32'd0, b_pc}, 64'd5);

    // Three-cycle stall holding pc=5, then pc=6 with no gap.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      chk("stall_pc", {32'd0, b_pc}, 64'd5);
      chk("stall_inst", b_inst, 64'hC0DE0005_5EED0005);
    end
    step(0, 0, 0);
    chk("release_pc", {32'd0, b_pc}, 64'd6);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pc9", {32'd0, b_pc}, 64'd9);

    // Redirect to 0x40 while pc=9 is presented.
    branch_flag = 1'b1; branch_pc = 32'h40;
    #1;
    chk("branch_addr", {49'd0, b_addr}, 64'h40);
    step(1, 32'h40, 0);
    chk("target_pc", {32'd0, b_pc}, 64'h40);
    step(0, 0, 0);
    chk("target_plus1", {32'd0, b_pc}, 64'h41);

    // Redirect during a stall with a live hold: hold is dropped.
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'h100, 1);
    chk("branch_over_hold", {32'd0, b_pc}, 64'h100);

    // Branch on the cycle interlock drops.
    step(0, 0, 1);
    step(1, 32'h200, 0);
    chk("branch_on_release", {32'd0, b_pc}, 64'h200);

    // Asynchronous reset mid-stall.
    step(0, 0, 1);
    step(0, 0, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_pc", {32'd0, b_pc}, 64'd0);
    chk("async_inst", b_inst, 64'hFC000000_FC000000);
    chk("async_valid", {63'd0, b_valid}, 64'd0);
    interlock = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Interlock in the first cycle after reset: NOP stays, fetch_pc kept.
    step(0, 0, 1);
    chk("early_stall_valid", {63'd0, b_valid}, 64'd0);
    step(0, 0, 0);
    chk("restart_pc", {32'd0, b_pc}, 64'd0);

    // Small-address instance: aliasing across 2^4.
    branch_flag = 1'b1; branch_pc = 32'hE;
    #1;
    chk("small_addr_e", {60'd0, s_addr}, 64'hE);
    step(1, 32'hE, 0);
    branch_flag = 1'b0; #1;
    chk("small_addr_f", {60'd0, s_addr}, 64'hF);
    chk("small_pc_e", {32'd0, s_pc}, 64'hE);
    step(0, 0, 0);
    chk("small_addr_0", {60'd0, s_addr}, 64'h0);
    chk("small_pc_f", {32'd0, s_pc}, 64'hF);
    step(0, 0, 0);
    chk("small_pc_10", {32'd0, s_pc}, 64'h10);
    chk("small_inst_alias", s_inst, 64'hC0DE0000_5EED0000);

    // 32-bit wrap of the fetch pc.
    step(1, 32'hFFFF_FFFF, 0);
    chk("wrap_top", {32'd0, b_pc}, 64'hFFFF_FFFF);
    step(0, 0, 0);
    chk("wrap_zero", {32'd0, b_pc}, 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage directly upstream of decode in the 2nd-generation dual-issue core.
- Generates bundle addresses for a 64-bit-wide synchronous instruction BRAM (1-cycle read latency).
- Presents {pc, 64-bit bundle} to decode. Honours decode's interlock (hold) and branch redirect (branch_flag/branch_pc).
- Bundle addresses increment by 1 per 64-bit bundle, matching the pc+1 link value decode writes for Bl/Blrr.

Parameters:
- ADDR_W, 15, instruction-memory address width in bundles; imem_addr = low ADDR_W bits of the fetch pc.
- RESET_PC, 32'h0, first bundle address fetched after reset release.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- interlock  input  1  decode stall; the presented bundle must stay stable
- branch_flag  input  1  registered redirect from decode; valid for exactly one cycle
- branch_pc  input  32  redirect target bundle address, sampled when branch_flag=1
- imem_addr  output  ADDR_W  BRAM read address; combinational
- imem_dout  input  64  BRAM read data for the address issued the previous cycle
- pc  output  32  pc of the bundle presented to decode
- inst  output  64  bundle presented to decode; upper slot [63:32], lower slot [31:0]
- fetch_valid  output  1  presented bundle is real (debug only; decode does not need it)

Behaviour:
- Reset is asynchronous and active-low: clk, rstn. While rstn=0:
  - fetch_pc=RESET_PC, inflight_valid=0, hold_valid=0.
  - Outputs: pc=0, inst=NOP_BUNDLE ({Nop,26'b0,Nop,26'b0}), fetch_valid=0.
  - Reset may assert mid-stall or mid-redirect; all in-flight state is discarded.
- Internal registers:
  - fetch_pc (32): next address to issue.
  - inflight_pc (32) and inflight_valid: describe the BRAM data arriving this cycle.
  - hold_pc (32), hold_inst (64), hold_valid: stall capture.
- imem_addr = branch_flag ? branch_pc[ADDR_W-1:0] : fetch_pc[ADDR_W-1:0].
- Presented bundle (combinational mux), in priority order:
  - hold_valid=1: hold_pc/hold_inst.
  - else inflight_valid=1: inflight_pc/imem_dout.
  - else pc=0, inst=NOP_BUNDLE.
  - fetch_valid = hold_valid | inflight_valid.
- Per-cycle update, priority branch_flag > interlock > normal:
  - branch_flag=1, regardless of interlock:
    - hold_valid<=0, inflight_valid<=1, inflight_pc<=branch_pc, fetch_pc<=branch_pc+1.
    - The presented bundle is dropped; decode is flushing this cycle.
    - Target data is presented the next cycle: exactly one flush cycle, no extra bubble.
  - interlock=1, branch_flag=0:
    - If hold_valid=0 and inflight_valid=1: hold_pc<=inflight_pc, hold_inst<=imem_dout, hold_valid<=1.
    - inflight_valid<=0 (the read issued this cycle is discarded).
    - fetch_pc unchanged.
    - pc/inst remain bit-stable for the whole stall, any length.
  - interlock=0, branch_flag=0:
    - hold_valid<=0, inflight_valid<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1.
    - On stall release, the hold is consumed and fetch_pc is issued in the same cycle, so there is zero bubble.
- Timing and address rules:
  - Latency: address issued in cycle n is presented in cycle n+1 when no stall or redirect intervenes.
  - Sustained throughput: one bundle per cycle.
  - fetch_pc increments as a 32-bit value and wraps at 2^32. imem_addr uses the truncated value, so addresses ≥2^ADDR_W alias.
- Boundary cases:
  - branch_flag on the same cycle interlock deasserts: branch wins; the hold is discarded.
  - interlock asserted in the first cycle after reset (nothing in flight): the hold stays empty, NOP is presented, fetch_pc is retained.
- No combinational path from interlock or branch_flag to pc/inst. Paths only go to imem_addr (branch_flag) and to register next-state logic.

Decomposition:
- inst_package:
  - Add NOP_BUNDLE localparam, built from the existing Nop opcode.
  - Add BUNDLE_W=64.
- Sub-module fetch_hold (stall capture register plus output mux, ~50 lines) keeps fetch's top level to PC/redirect sequencing.

Test Plan:
- Reset release, RESET_PC=0, BRAM[k]=k-tagged bundles, no stall → cycle 1 pc=0, then pc=1,2,3… one per cycle, inst=BRAM[pc].
- interlock high for 3 cycles while pc=5 is presented → pc=5/inst=BRAM[5] constant all 3 cycles; after release pc=6 on the next cycle, no gap, no duplicate.
- branch_flag=1, branch_pc=0x40 while pc=9 is presented → imem_addr=0x40 that cycle; next cycle pc=0x40, then 0x41.
- branch_flag=1 with interlock=1 and hold_valid=1 → hold dropped; next cycle pc=branch_pc.
- rstn pulsed low mid-stall (asynchronous, between clock edges) → outputs immediately pc=0, inst=NOP_BUNDLE, fetch_valid=0; after release fetch restarts at RESET_PC.
- ADDR_W=4, run from fetch_pc=0xE → imem_addr 0xE,0xF,0x0; pc outputs 0xE,0xF,0x10.
